// File: rtl/barrel_shift_sequencer.sv
// Sequencer for an external combinational barrel shifter: captures a pattern,
// steps the shift amount every TICK_DIV cycles and registers each result.
`timescale 1ns/1ps
module barrel_shift_sequencer #(
    parameter int WIDTH    = 16,
    parameter int SHW      = 5,
    parameter int TICK_DIV = 50000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] pattern_in,
    input  logic [WIDTH-1:0] shifter_result,
    output logic [WIDTH-1:0] pattern_out,
    output logic [SHW-1:0]   shift_out,
    output logic [WIDTH-1:0] result_out,
    output logic             step_valid,
    output logic             busy,
    output logic             done
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [SHW-1:0] SHIFT_MAX = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg;
    logic [1:0]       mode_reg;
    logic             dir_down_reg;
    logic [CW-1:0]    tick_cnt_reg;
    logic [WIDTH-1:0] pattern_reg;
    logic [SHW-1:0]   shift_reg;
    logic [WIDTH-1:0] result_reg;
    logic             step_valid_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [SHW-1:0]   shift_next;
    logic             dir_down_next;
    logic             last_capture;
    logic             tick_hit;

    assign tick_hit = (tick_cnt_reg == TICK_LAST);

    // Shift amount that follows the current one; one-shot modes flag their endpoint instead.
    always_comb begin
        shift_next    = shift_reg;
        dir_down_next = dir_down_reg;
        last_capture  = 1'b0;
        case (mode_reg)
            2'b00: begin
                if (shift_reg == SHIFT_MAX) last_capture = 1'b1;
                else                        shift_next   = shift_reg + SHW'(1);
            end
            2'b01: begin
                if (shift_reg == '0) last_capture = 1'b1;
                else                 shift_next   = shift_reg - SHW'(1);
            end
            2'b10: begin
                if (!dir_down_reg) begin
                    if (shift_reg == SHIFT_MAX) begin
                        dir_down_next = 1'b1;
                        shift_next    = shift_reg - SHW'(1);
                    end else begin
                        shift_next    = shift_reg + SHW'(1);
                    end
                end else begin
                    if (shift_reg == '0) begin
                        dir_down_next = 1'b0;
                        shift_next    = shift_reg + SHW'(1);
                    end else begin
                        shift_next    = shift_reg - SHW'(1);
                    end
                end
            end
            default: shift_next = (shift_reg == SHIFT_MAX) ? '0 : shift_reg + SHW'(1);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            mode_reg       <= 2'b00;
            dir_down_reg   <= 1'b0;
            tick_cnt_reg   <= '0;
            pattern_reg    <= '0;
            shift_reg      <= '0;
            result_reg     <= '0;
            step_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            step_valid_reg <= 1'b0;
            done_reg       <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start && !stop) begin
                        pattern_reg  <= pattern_in;
                        mode_reg     <= mode;
                        shift_reg    <= (mode == 2'b01) ? SHIFT_MAX : '0;
                        tick_cnt_reg <= '0;
                        dir_down_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        state_reg    <= RUN;
                    end
                end
                RUN: begin
                    // An abort beats a tick landing on the same edge.
                    if (stop) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else if (tick_hit) begin
                        tick_cnt_reg   <= '0;
                        result_reg     <= shifter_result;
                        step_valid_reg <= 1'b1;
                        shift_reg      <= shift_next;
                        dir_down_reg   <= dir_down_next;
                        if (last_capture) begin
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= DONE;
                        end
                    end else begin
                        tick_cnt_reg <= tick_cnt_reg + CW'(1);
                    end
                end
                DONE: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign pattern_out = pattern_reg;
    assign shift_out   = shift_reg;
    assign result_out  = result_reg;
    assign step_valid  = step_valid_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
endmodule

// File: tb/tb_barrel_shift_sequencer.sv
// Bench for barrel_shift_sequencer: two instances (TICK_DIV=4 and TICK_DIV=1),
// each driving a rotate-left shifter model; expected captures are queued per run.
`timescale 1ns/1ps
module tb_barrel_shift_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rotl(input logic [15:0] v, input logic [4:0] s);
        logic [31:0] w;
        w = {v, v} << s[3:0];
        return w[31:16];
    endfunction

    logic        start4 = 1'b0, stop4 = 1'b0;
    logic [1:0]  mode4 = 2'b00;
    logic [15:0] pin4 = 16'h0;
    logic [15:0] pout4, res4, sres4;
    logic [4:0]  sh4;
    logic        sv4, busy4, done4;

    logic        start1 = 1'b0, stop1 = 1'b0;
    logic [1:0]  mode1 = 2'b00;
    logic [15:0] pin1 = 16'h0;
    logic [15:0] pout1, res1, sres1;
    logic [4:0]  sh1;
    logic        sv1, busy1, done1;

    assign sres4 = rotl(pout4, sh4);
    assign sres1 = rotl(pout1, sh1);

    barrel_shift_sequencer #(.WIDTH(16), .SHW(5), .TICK_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .stop(stop4), .mode(mode4),
        .pattern_in(pin4), .shifter_result(sres4), .pattern_out(pout4),
        .shift_out(sh4), .result_out(res4), .step_valid(sv4), .busy(busy4), .done(done4));

    barrel_shift_sequencer #(.WIDTH(16), .SHW(5), .TICK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .stop(stop1), .mode(mode1),
        .pattern_in(pin1), .shifter_result(sres1), .pattern_out(pout1),
        .shift_out(sh1), .result_out(res1), .step_valid(sv1), .busy(busy1), .done(done1));

    typedef struct {
        int          cyc;
        logic [15:0] result;
        logic [4:0]  shift;
        logic        done;
        logic        busy;
    } exp_t;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] pat;
        logic [15:0] pat_mid;
        logic        hold;
    } run_t;

    exp_t q4[$];
    exp_t q1[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    task automatic push(input int d, input int c, input logic [15:0] r, input logic [4:0] s,
                        input logic dn, input logic bz);
        exp_t e;
        e.cyc = c; e.result = r; e.shift = s; e.done = dn; e.busy = bz;
        if (d == 0) q4.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic mon(input int d, input logic sv, input logic [15:0] res, input logic [4:0] sh,
                       input logic dn, input logic bz);
        exp_t e;
        int   sz;
        sz = (d == 0) ? q4.size() : q1.size();
        if (sv) begin
            if (sz == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_step dut%0d cyc=%0d actual=1 required=0", d, cyc);
            end else begin
                if (d == 0) e = q4.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("step_cycle_d%0d", d), cyc, e.cyc);
                chk($sformatf("result_d%0d", d), {16'h0, res}, {16'h0, e.result});
                chk($sformatf("shift_d%0d", d), {27'h0, sh}, {27'h0, e.shift});
                chk($sformatf("done_d%0d", d), {31'h0, dn}, {31'h0, e.done});
                chk($sformatf("busy_d%0d", d), {31'h0, bz}, {31'h0, e.busy});
            end
        end else begin
            if (dn) chk($sformatf("stray_done_d%0d", d), {31'h0, dn}, 32'h0);
            if (sz > 0) begin
                if (d == 0) e = q4[0];
                else        e = q1[0];
                if (e.cyc <= cyc) begin
                    if (d == 0) void'(q4.pop_front());
                    else        void'(q1.pop_front());
                    checks++; failures++;
                    $display("FAIL missing_step dut%0d cyc=%0d actual=0 required=1", d, cyc);
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        mon(0, sv4, res4, sh4, done4, busy4);
        mon(1, sv1, res1, sh1, done1, busy1);
    endtask

    task automatic drain(input int budget);
        for (int n = 0; n < budget && (q4.size() > 0 || q1.size() > 0); n++) cycle();
        if (q4.size() > 0 || q1.size() > 0) begin
            checks++; failures++;
            $display("FAIL drain_timeout cyc=%0d actual=%0d required=0", cyc, q4.size() + q1.size());
            q4.delete();
            q1.delete();
        end
    endtask

    run_t runs[2];
    int   pp[32];
    int   k;
    int   s_i;
    int   s_after;

    initial begin
        runs[0] = '{mode: 2'b00, pat: 16'h0001, pat_mid: 16'hA5A5, hold: 1'b0};
        runs[1] = '{mode: 2'b01, pat: 16'hFFFE, pat_mid: 16'h3C00, hold: 1'b1};
        pp = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
               14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1};

        // Reset state
        cycle();
        cycle();
        chk("rst_pattern", {16'h0, pout4}, 32'h0);
        chk("rst_shift", {27'h0, sh4}, 32'h0);
        chk("rst_result", {16'h0, res4}, 32'h0);
        chk("rst_flags", {29'h0, sv4, busy4, done4}, 32'h0);
        chk("rst_d1", {10'h0, sh1, busy1, pout1}, 32'h0);
        rst_n = 1'b1;
        cycle();
        chk("post_rst_busy", {31'h0, busy4}, 32'h0);

        // One-shot sweeps from the run table
        for (int r = 0; r < 2; r++) begin
            k = cyc + 1;
            mode4 = runs[r].mode;
            pin4 = runs[r].pat;
            start4 = 1'b1;
            for (int i = 1; i <= 16; i++) begin
                s_i = (runs[r].mode == 2'b00) ? i - 1 : 16 - i;
                if (i < 16) s_after = (runs[r].mode == 2'b00) ? i : 15 - i;
                else        s_after = (runs[r].mode == 2'b00) ? 15 : 0;
                push(0, k + 4 * i, rotl(runs[r].pat, 5'(s_i)), 5'(s_after), i == 16, i != 16);
            end
            cycle();
            if (!runs[r].hold) start4 = 1'b0;
            repeat (8) cycle();
            pin4 = runs[r].pat_mid;
            mode4 = ~runs[r].mode;
            drain(100);
            chk($sformatf("pattern_hold_run%0d", r), {16'h0, pout4}, {16'h0, runs[r].pat});
            chk($sformatf("final_shift_run%0d", r), {27'h0, sh4},
                (runs[r].mode == 2'b00) ? 32'd15 : 32'd0);
            chk($sformatf("final_busy_run%0d", r), {31'h0, busy4}, 32'h0);
            if (runs[r].hold) begin
                cycle();
                chk("after_done_busy", {31'h0, busy4}, 32'h0);
                chk("after_done_done", {31'h0, done4}, 32'h0);
                push(0, cyc + 5, runs[r].pat_mid, 5'd1, 1'b0, 1'b1);
                cycle();
                chk("restart_busy", {31'h0, busy4}, 32'h1);
                start4 = 1'b0;
                drain(50);
                stop4 = 1'b1;
                cycle();
                stop4 = 1'b0;
                chk("restart_stop_busy", {31'h0, busy4}, 32'h0);
                chk("restart_stop_shift", {27'h0, sh4}, 32'd1);
                chk("restart_stop_result", {16'h0, res4}, {16'h0, runs[r].pat_mid});
            end
            repeat (3) cycle();
        end

        // Ping-pong at one step per cycle, then abort with shift_out at 2
        k = cyc + 1;
        mode1 = 2'b10;
        pin1 = 16'hFD55;
        start1 = 1'b1;
        for (int i = 1; i <= 32; i++)
            push(1, k + i, rotl(16'hFD55, 5'(pp[i-1])), (i < 32) ? 5'(pp[i]) : 5'd2, 1'b0, 1'b1);
        cycle();
        start1 = 1'b0;
        mode1 = 2'b00;
        drain(100);
        stop1 = 1'b1;
        cycle();
        stop1 = 1'b0;
        chk("pp_stop_shift", {27'h0, sh1}, 32'd2);
        chk("pp_stop_busy", {31'h0, busy1}, 32'h0);
        chk("pp_stop_result", {16'h0, res1}, {16'h0, rotl(16'hFD55, 5'd1)});
        repeat (3) cycle();

        // Continuous wrap, then a stop landing on a tick edge
        k = cyc + 1;
        mode4 = 2'b11;
        pin4 = 16'h1234;
        start4 = 1'b1;
        for (int i = 1; i <= 17; i++)
            push(0, k + 4 * i, rotl(16'h1234, 5'((i - 1) % 16)), 5'(i % 16), 1'b0, 1'b1);
        cycle();
        start4 = 1'b0;
        drain(200);
        repeat (3) cycle();
        stop4 = 1'b1;
        cycle();
        stop4 = 1'b0;
        chk("tick_stop_valid", {31'h0, sv4}, 32'h0);
        chk("tick_stop_busy", {31'h0, busy4}, 32'h0);
        chk("tick_stop_result", {16'h0, res4}, 32'h1234);
        chk("tick_stop_shift", {27'h0, sh4}, 32'd1);

        // start and stop together in IDLE
        start4 = 1'b1;
        stop4 = 1'b1;
        pin4 = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("start_stop_busy", {31'h0, busy4}, 32'h0);
            chk("start_stop_pattern", {16'h0, pout4}, 32'h1234);
        end
        start4 = 1'b0;
        stop4 = 1'b0;
        cycle();

        // Asynchronous reset in the middle of a run
        k = cyc + 1;
        mode4 = 2'b11;
        pin4 = 16'h00F0;
        start4 = 1'b1;
        push(0, k + 4, 16'h00F0, 5'd1, 1'b0, 1'b1);
        cycle();
        start4 = 1'b0;
        drain(20);
        cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pattern", {16'h0, pout4}, 32'h0);
        chk("async_rst_shift", {27'h0, sh4}, 32'h0);
        chk("async_rst_result", {16'h0, res4}, 32'h0);
        chk("async_rst_flags", {29'h0, sv4, busy4, done4}, 32'h0);
        cycle();
        rst_n = 1'b1;
        repeat (6) cycle();
        chk("post_async_busy", {31'h0, busy4}, 32'h0);
        chk("post_async_shift", {27'h0, sh4}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
